// File: rtl/calc_key_ctrl.sv
// calc_key_ctrl: key sequencer between the PS/2 decoder and the calculator ALU.
// Builds two BCD operands plus an operator from ASCII key strobes and issues one
// req/ack transaction per calculation; latches and displays the result.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   key_valid, key_code   - one-cycle ASCII key strobe
//   alu_req               - request, held until alu_ack
//   alu_a, alu_b, alu_op  - BCD operands and operator (00 add, 01 sub, 10 mul)
//   alu_ack, alu_result,
//   alu_err               - one-cycle acknowledge with result and error flag
//   disp_bcd, disp_err    - display value and error indicator
//   key_drop              - pulse when a key is discarded during a request
//
// Build option: CALC_CHAIN_EN - an operator key while a result is shown
// reuses that result as operand A.

module calc_key_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    output logic                  alu_req,
    output logic [4*DIGITS-1:0]   alu_a,
    output logic [4*DIGITS-1:0]   alu_b,
    output logic [1:0]            alu_op,
    input  logic                  alu_ack,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_err,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_err,
    output logic                  key_drop
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_REQ  = 2'd2,
        S_SHOW = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic           err_q, err_d;
    logic           req_q, req_d;
    logic           drop_q, drop_d;
    logic [W-1:0]   disp_q, disp_d;

    // ------------------------------------------------------------------
    // Key classification
    // ------------------------------------------------------------------
    logic       k_dig;
    logic       k_ent;
    logic       k_op;
    logic       k_bs;
    logic       k_clr;
    logic [3:0] k_val;
    logic [1:0] k_opc;

    always_comb begin
        k_dig = key_valid && (key_code >= 8'h30) && (key_code <= 8'h39);
        k_ent = key_valid && (key_code == 8'h0a);
        k_bs  = key_valid && (key_code == 8'h08);
        k_clr = key_valid && (key_code == 8'h1b);
        k_op  = key_valid && ((key_code == 8'h2b) ||
                              (key_code == 8'h2d) ||
                              (key_code == 8'h2a));
        k_val = key_code[3:0];
        k_opc = 2'b00;
        if (key_code == 8'h2d) begin
            k_opc = 2'b01;
        end else if (key_code == 8'h2a) begin
            k_opc = 2'b10;
        end
    end

    // ------------------------------------------------------------------
    // Operand edit: result of applying a digit or backspace to the
    // operand currently being entered.
    // ------------------------------------------------------------------
    logic [W-1:0]   cur;
    logic [W-1:0]   ed_val;
    logic [CW-1:0]  ed_cnt;
    logic [W+3:0]   shl;

    always_comb begin
        cur    = (state_q == S_B) ? b_q : a_q;
        shl    = {cur, k_val};
        ed_val = cur;
        ed_cnt = cnt_q;
        if (k_dig) begin
            // Full operand drops the digit; a leading zero is not counted.
            if ((cnt_q != CNT_MAX) && !((cnt_q == '0) && (k_val == 4'd0))) begin
                ed_val = shl[W-1:0];
                ed_cnt = cnt_q + CW'(1);
            end
        end else if (k_bs) begin
            if (cnt_q != '0) begin
                ed_val = cur >> 4;
                ed_cnt = cnt_q - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        drop_d  = 1'b0;

        unique case (state_q)
            S_A, S_B: begin
                unique case (1'b1)
                    k_clr: begin
                        a_d     = '0;
                        b_d     = '0;
                        r_d     = '0;
                        cnt_d   = '0;
                        op_d    = 2'b00;
                        err_d   = 1'b0;
                        state_d = S_A;
                    end
                    k_dig, k_bs: begin
                        cnt_d = ed_cnt;
                        if (state_q == S_A) begin
                            a_d = ed_val;
                        end else begin
                            b_d = ed_val;
                        end
                    end
                    k_op: begin
                        op_d = k_opc;
                        if (state_q == S_A) begin
                            b_d     = '0;
                            cnt_d   = '0;
                            state_d = S_B;
                        end
                    end
                    k_ent: begin
                        if (state_q == S_B) begin
                            state_d = S_REQ;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            S_REQ: begin
                // The handshake always completes; every key here is lost.
                drop_d = key_valid;
                if (alu_ack) begin
                    r_d     = alu_result;
                    err_d   = alu_err;
                    state_d = S_SHOW;
                end
            end

            S_SHOW: begin
                unique case (1'b1)
                    k_clr: begin
                        a_d     = '0;
                        b_d     = '0;
                        r_d     = '0;
                        cnt_d   = '0;
                        op_d    = 2'b00;
                        err_d   = 1'b0;
                        state_d = S_A;
                    end
                    k_dig: begin
                        b_d     = '0;
                        r_d     = '0;
                        err_d   = 1'b0;
                        a_d     = W'(k_val);
                        cnt_d   = (k_val == 4'd0) ? '0 : CW'(1);
                        state_d = S_A;
                    end
`ifdef CALC_CHAIN_EN
                    k_op: begin
                        if (!err_q) begin
                            a_d     = r_q;
                            b_d     = '0;
                            cnt_d   = '0;
                            op_d    = k_opc;
                            state_d = S_B;
                        end
                    end
`else
                    k_op: begin
                    end
`endif
                    default: begin
                    end
                endcase
            end

            default: begin
                state_d = S_A;
            end
        endcase

        req_d = (state_d == S_REQ);

        unique case (state_d)
            S_A:     disp_d = a_d;
            S_B:     disp_d = b_d;
            S_REQ:   disp_d = b_d;
            S_SHOW:  disp_d = r_d;
            default: disp_d = a_d;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            disp_q  <= disp_d;
        end
    end

    assign alu_req  = req_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign disp_bcd = disp_q;
    assign disp_err = err_q;
    assign key_drop = drop_q;

endmodule
